// File: rtl/lut_neuron_sequencer_pkg.sv
// Shared types and helpers for the time-multiplexed LUT neuron sequencer.
// Holds the FSM state encoding, config-select codes and fan-in field extraction.
package lut_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic CFG_SEL_TT  = 1'b0;
  localparam logic CFG_SEL_IDX = 1'b1;

  // Widest config word the extractor accepts; callers size-cast into it.
  localparam int WORD_MAX = 256;

  function automatic logic [31:0] idx_field(input logic [WORD_MAX-1:0] word,
                                            input int unsigned k,
                                            input int unsigned idx_w);
    logic [WORD_MAX-1:0] mask;
    logic [WORD_MAX-1:0] field;
    mask  = (WORD_MAX'(1) << idx_w) - WORD_MAX'(1);
    field = (word >> (k * idx_w)) & mask;
    return field[31:0];
  endfunction

endpackage

// File: rtl/lut_neuron_sequencer_if.sv
// Config, input-vector and result handshakes of the LUT neuron sequencer.
// master drives config/input/out_ready; slave is the sequencer itself.
interface lut_seq_if #(
  parameter int IN_WIDTH  = 48,
  parameter int N_NEURONS = 16,
  parameter int FAN_IN    = 6
);
  localparam int TT_W = 2 ** FAN_IN;
  localparam int AW   = $clog2(N_NEURONS);

  logic                 cfg_we;
  logic                 cfg_sel;
  logic [AW-1:0]        cfg_addr;
  logic [TT_W-1:0]      cfg_wdata;
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_NEURONS-1:0] out_data;
  logic                 busy;
  logic                 cfg_err;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, cfg_err
  );
endinterface

// File: rtl/lut_neuron_sequencer_cfg_mem.sv
// Per-neuron truth tables and packed fan-in index words, one write port each.
// Reads are combinational so the evaluator sees neuron n in the same cycle.
module lut_cfg_mem #(
  parameter int N_NEURONS = 16,
  parameter int TT_W      = 64,
  parameter int AW        = $clog2(N_NEURONS)
) (
  input  logic            clk,
  input  logic            i_we_tt,
  input  logic            i_we_idx,
  input  logic [AW-1:0]   i_waddr,
  input  logic [TT_W-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [TT_W-1:0] o_tt,
  output logic [TT_W-1:0] o_idx
);
  // Intentionally unreset: contents survive rst and are undefined until written.
  logic [TT_W-1:0] r_tt_mem  [N_NEURONS];
  logic [TT_W-1:0] r_idx_mem [N_NEURONS];

  always_ff @(posedge clk) begin
    if (i_we_tt) begin
      r_tt_mem[i_waddr] <= i_wdata;
    end
    if (i_we_idx) begin
      r_idx_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_tt  = r_tt_mem[i_raddr];
  assign o_idx = r_idx_mem[i_raddr];
endmodule

// File: rtl/lut_neuron_sequencer.sv
// Evaluates N_NEURONS 6-input LUT neurons, one per clock, on a latched vector.
// Config writes are only honoured in IDLE; others are dropped and flag cfg_err.
module lut_neuron_sequencer
  import lut_seq_pkg::*;
#(
  parameter int IN_WIDTH  = 48,
  parameter int N_NEURONS = 16,
  parameter int FAN_IN    = 6
) (
  input logic       clk,
  input logic       rst,
  lut_seq_if.slave  bus
);
  localparam int IDX_W = $clog2(IN_WIDTH);
  localparam int TT_W  = 2 ** FAN_IN;
  localparam int AW    = $clog2(N_NEURONS);
  localparam logic [AW-1:0]  LAST_N = AW'(N_NEURONS - 1);
  localparam logic [IDX_W:0] IN_LIM = IN_WIDTH[IDX_W:0];

  state_t               r_state;
  logic [AW-1:0]        r_n;
  logic [IN_WIDTH-1:0]  r_in;
  logic [N_NEURONS-1:0] r_out;
  logic                 r_out_valid;
  logic                 r_busy;
  logic                 r_cfg_err;

  logic                 w_cfg_ok;
  logic [TT_W-1:0]      w_tt;
  logic [TT_W-1:0]      w_idx_word;
  logic [FAN_IN-1:0]    w_addr;
  logic                 w_bit;

  assign w_cfg_ok = bus.cfg_we && (r_state == IDLE);

  lut_cfg_mem #(
    .N_NEURONS (N_NEURONS),
    .TT_W      (TT_W),
    .AW        (AW)
  ) u_cfg_mem (
    .clk      (clk),
    .i_we_tt  (w_cfg_ok && (bus.cfg_sel == CFG_SEL_TT)),
    .i_we_idx (w_cfg_ok && (bus.cfg_sel == CFG_SEL_IDX)),
    .i_waddr  (bus.cfg_addr),
    .i_wdata  (bus.cfg_wdata),
    .i_raddr  (r_n),
    .o_tt     (w_tt),
    .o_idx    (w_idx_word)
  );

  // Gather one activation bit per fan-in field; out-of-range indices read 0.
  for (genvar gi = 0; gi < FAN_IN; gi++) begin : g_gather
    logic [IDX_W-1:0] w_idx;
    assign w_idx      = IDX_W'(idx_field(WORD_MAX'(w_idx_word), gi, IDX_W));
    assign w_addr[gi] = ({1'b0, w_idx} < IN_LIM) ? r_in[w_idx] : 1'b0;
  end

  assign w_bit = w_tt[w_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_in        <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      if (bus.cfg_we && (r_state != IDLE)) begin
        r_cfg_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_in    <= bus.in_data;
            r_n     <= '0;
            r_busy  <= 1'b1;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          r_out[r_n] <= w_bit;
          if (r_n == LAST_N) begin
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_n <= r_n + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out;
  assign bus.busy      = r_busy;
  assign bus.cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_lut_neuron_sequencer.sv
// Directed bench for lut_neuron_sequencer: identity, AND6, backpressure,
// dropped busy-time config writes and reset during evaluation.
module tb_lut_neuron_sequencer;
  import lut_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  lut_seq_if #(.IN_WIDTH(48), .N_NEURONS(16), .FAN_IN(6)) bus ();

  lut_neuron_sequencer #(
    .IN_WIDTH  (48),
    .N_NEURONS (16),
    .FAN_IN    (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] idx_word(input int f0, input int f1, input int f2,
                                           input int f3, input int f4, input int f5);
    logic [63:0] w;
    w        = '0;
    w[5:0]   = f0[5:0];
    w[11:6]  = f1[5:0];
    w[17:12] = f2[5:0];
    w[23:18] = f3[5:0];
    w[29:24] = f4[5:0];
    w[35:30] = f5[5:0];
    return w;
  endfunction

  task automatic cfg_write(input logic sel, input int addr, input logic [63:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_addr  = 4'(addr);
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic accept(input string tag, input logic [47:0] d);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) check({tag, "_timeout"}, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [47:0] d, input logic [15:0] exp,
                         output int lat);
    accept(tag, d);
    wait_valid(tag, lat);
    check({tag, "_out"}, 64'(bus.out_data), 64'(exp));
    $display("xfer %s in=%h out=%h exp=%h lat=%0d", tag, d, bus.out_data, exp, lat);
    handshake();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] held;
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = CFG_SEL_TT;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    check("rst_held_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Identity buffer config
    for (int n = 0; n < 16; n++) begin
      cfg_write(CFG_SEL_TT, n, 64'hAAAA_AAAA_AAAA_AAAA);
      cfg_write(CFG_SEL_IDX, n, idx_word(n, 0, 0, 0, 0, 0));
    end
    run_vec("ident", 48'h0000_0000_A5C3, 16'hA5C3, lat);
    check("ident_lat", 64'(lat), 64'd16);

    // AND6 on neuron 0; other neurons still copy their input bit
    cfg_write(CFG_SEL_TT, 0, 64'h8000_0000_0000_0000);
    cfg_write(CFG_SEL_IDX, 0, idx_word(10, 11, 12, 13, 14, 15));
    run_vec("and6_ones", 48'h0000_0000_FC00, 16'hFC01, lat);
    run_vec("and6_one0", 48'h0000_0000_F800, 16'hF800, lat);
    cfg_write(CFG_SEL_IDX, 0, idx_word(10, 11, 12, 13, 14, 63));
    run_vec("and6_oob", 48'h0000_0000_FC00, 16'hFC00, lat);
    cfg_write(CFG_SEL_TT, 0, 64'hAAAA_AAAA_AAAA_AAAA);
    cfg_write(CFG_SEL_IDX, 0, idx_word(0, 0, 0, 0, 0, 0));

    // Backpressure: hold result for 10 cycles
    accept("bp", 48'h0000_0000_1234);
    wait_valid("bp", lat);
    check("bp_out", 64'(bus.out_data), 64'h1234);
    held = bus.out_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_stable", 64'(bus.out_data), 64'(held));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_busy", 64'(bus.busy), 64'd1);
    end
    $display("xfer bp in=%h out=%h held=10", 48'h1234, bus.out_data);
    handshake();
    check("bp_post_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_post_valid", 64'(bus.out_valid), 64'd0);
    check("bp_post_busy", 64'(bus.busy), 64'd0);

    // Config write during EVAL is dropped and latches cfg_err
    accept("busy_cfg", 48'h0000_0000_0008);
    repeat (4) tick();
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = CFG_SEL_TT;
    bus.cfg_addr  = 4'd3;
    bus.cfg_wdata = 64'h0;
    tick();
    bus.cfg_we    = 1'b0;
    check("busy_cfg_err", 64'(bus.cfg_err), 64'd1);
    wait_valid("busy_cfg", lat);
    check("busy_cfg_out", 64'(bus.out_data), 64'h0008);
    $display("xfer busy_cfg in=%h out=%h", 48'h0008, bus.out_data);
    handshake();
    run_vec("busy_cfg_recheck", 48'h0000_0000_0008, 16'h0008, lat);
    check("busy_cfg_err_sticky", 64'(bus.cfg_err), 64'd1);

    // Config write and accept in the same IDLE cycle: new config applies
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = CFG_SEL_TT;
    bus.cfg_addr  = 4'd3;
    bus.cfg_wdata = 64'h0;
    bus.in_data   = 48'h0000_0000_0008;
    bus.in_valid  = 1'b1;
    tick();
    bus.cfg_we    = 1'b0;
    bus.in_valid  = 1'b0;
    wait_valid("same_cyc", lat);
    check("same_cyc_out", 64'(bus.out_data), 64'h0000);
    $display("xfer same_cyc in=%h out=%h", 48'h0008, bus.out_data);
    handshake();
    cfg_write(CFG_SEL_TT, 3, 64'hAAAA_AAAA_AAAA_AAAA);

    // Reset in the 5th EVAL cycle discards the vector
    accept("mid_rst", 48'h0000_0000_A5C3);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data", 64'(bus.out_data), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_idle", 64'(bus.in_ready), 64'd1);
    check("mid_rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    check("mid_rst_no_out", 64'(bus.out_valid), 64'd0);
    run_vec("resubmit", 48'h0000_0000_A5C3, 16'hA5C3, lat);
    check("resubmit_lat", 64'(lat), 64'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lut_neuron_sequencer.md
# lut_neuron_sequencer

Time-multiplexed evaluator for one layer of LogicNets-style LUT neurons. Each neuron is a 6-input, 1-output truth table with a programmable fan-in map. Instead of one hard-wired ROM per neuron, the block holds the truth tables and fan-in indices of N_NEURONS neurons in a small configuration memory and evaluates one neuron per clock against a latched input activation vector. It sits between two layer buffers and uses valid/ready handshakes on both sides.

## Interface
- IN_WIDTH, 48: bits in the input activation vector.
- N_NEURONS, 16: neurons evaluated per input vector.
- FAN_IN, 6: inputs per neuron. Truth table is 2**FAN_IN bits.
- IDX_W, $clog2(IN_WIDTH): width of one fan-in index. Requires FAN_IN*IDX_W <= 2**FAN_IN.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  1  0 = truth-table word, 1 = fan-in index word.
- cfg_addr  in  $clog2(N_NEURONS)  neuron number.
- cfg_wdata  in  2**FAN_IN  write data. For index words, field k occupies bits [k*IDX_W +: IDX_W]; upper bits are ignored.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  IN_WIDTH  activation vector.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  N_NEURONS  one result bit per neuron.
- busy  out  1  high in EVAL or HOLD.
- cfg_err  out  1  sticky; a write was attempted outside IDLE.

## Operation
- FSM states are IDLE, EVAL and HOLD.
- **IDLE**
  - in_ready=1.
  - cfg_we writes tt[cfg_addr] or idx[cfg_addr] at the edge.
  - in_valid&&in_ready latches in_data into in_reg, clears neuron counter n=0, and moves to EVAL.
- **EVAL**
  - Each cycle forms addr[k] = in_reg[idx[n][k]] for k=0..FAN_IN-1 (field 0 is the LSB).
  - An index >= IN_WIDTH reads 0.
  - Writes out_reg[n] = tt[n][addr] and increments n.
  - At n=N_NEURONS-1 the write happens and the FSM moves to HOLD.
  - Config memory reads are combinational (distributed RAM).
- **HOLD**
  - out_valid=1; out_data is stable.
  - out_valid&&out_ready moves to IDLE.
- cfg_we outside IDLE: write dropped, cfg_err set. cfg_err clears only on rst.
- cfg_we and input accept in the same IDLE cycle: both take effect. Evaluation uses the newly written config.
- Config memory is not reset and is retained across rst. Contents are undefined until written.

## Timing
- Reset values: state=IDLE, out_data=0, out_valid=0, busy=0, cfg_err=0, in_ready=1 from the first cycle after rst is released. rst held high forces in_ready=0.
- Accept at edge E: neurons 0..N-1 are written at edges E+1..E+N. out_valid is high from after E+N until handshake.
- Minimum period with out_ready tied high is N_NEURONS+2 cycles: handshake edge, then IDLE accept edge.
- out_data bits not yet evaluated hold the previous vector's values. out_data is only valid while out_valid.
- rst mid-EVAL/HOLD: at the next edge, IDLE, out_valid=0, out_data=0. In-flight vector is discarded with no output.
- in_ready is combinational from state only; no combinational path from in_valid or out_ready.

## Structure
- Package lut_seq_pkg holds:
  - the state enum (IDLE/EVAL/HOLD);
  - the CFG_SEL_TT=0 and CFG_SEL_IDX=1 constants;
  - the idx-field extract function.
- Sub-module lut_cfg_mem holds:
  - the tt and idx arrays, each with one write port;
  - a combinational read port addressed by n.
- The top holds the FSM, counter, in_reg, out_reg and bit-gather mux.

## Test plan
- **Reset:** hold rst 3 cycles then release. Required: out_valid=0, out_data=0, busy=0, cfg_err=0, in_ready=1 on the first cycle after release.
- **Identity (buffer):**
  - Setup: all tt=64'hAAAA_AAAA_AAAA_AAAA; neuron n idx field0=n.
  - Stimulus: in_data=48'h0000_0000_A5C3.
  - Required: out_data=16'hA5C3, out_valid rising exactly 16 edges after the accept edge.
- **AND6:**
  - Setup: neuron 0 tt=64'h8000_0000_0000_0000, idx fields 0..5 = 10..15.
  - Stimulus: in_data[15:10]=6'b111111, then 6'b111110.
  - Required: out_data[0]=1, then 0.
  - Extra: set field 5 to index 63. Required: out_data[0]=0 for the all-ones case.
- **Backpressure:**
  - Stimulus: out_ready=0 for 10 cycles in HOLD.
  - Required: out_valid=1 and out_data stable; in_ready=0 and busy=1 throughout.
  - After the handshake edge: in_ready=1, out_valid=0.
- **Config during busy:**
  - Stimulus: cfg_we on neuron 3 truth table in the 5th EVAL cycle.
  - Required: result equals the pre-write config; cfg_err=1 until rst.
  - Also: cfg_we together with in_valid in IDLE. Required: the new config is used.
- **Reset mid-EVAL:**
  - Stimulus: rst in the 5th EVAL cycle.
  - Required: next cycle IDLE, out_valid=0, out_data=0.
  - Resubmit the identity vector without rewriting config. Required: out_data=16'hA5C3.
